sl_pos_gen: RTL and testbench

- Vertical scanline-phase generator placed directly upstream of the scanline emulation stage.
- Tracks, per output line, the fractional position of that line inside its source line, using a 16-bit phase accumulator stepped once per output line.
- Emits an 8-bit relative position (sl_rel_pos_o) held constant over each active line, plus the video/sync stream delayed to stay aligned with it.

---
 rtl/sl_pos_gen_pkg.sv | 14 +
 rtl/sl_phase_acc.sv | 42 ++++
 rtl/sl_pos_gen.sv | 122 ++++++++++++
 tb/tb_sl_pos_gen.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/sl_pos_gen_pkg.sv
// Shared constants for the scanline-phase generator: state encoding, widths, sync polarity, pipeline depth.
package sl_pos_gen_pkg;

  localparam int unsigned COLOR_W_DEF = 8;
  localparam int unsigned PHASE_W_DEF = 16;
  localparam int unsigned REL_W       = 8;
  localparam int unsigned PIPE_DEPTH  = 2;

  localparam logic SYNC_ACTIVE = 1'b0;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FRAME = 1'b1;

endpackage

// File: rtl/sl_phase_acc.sv
// Phase accumulator: holds P, muxes frame load vs line step, and produces the carry and mid-line position.
module sl_phase_acc
  import sl_pos_gen_pkg::*;
#(
  parameter int unsigned PHASE_W = PHASE_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [PHASE_W-1:0] load_val_i,
  input  logic [PHASE_W-1:0] inc_i,
  output logic               carry_c,
  output logic [REL_W-1:0]   rel_c
);

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [PHASE_W:0]   sum_c;

  // Load has priority over step so a frame start never advances or strobes.
  always_comb begin
    sum_c   = {1'b0, phase_q} + {1'b0, inc_i};
    phase_d = phase_q;
    carry_c = 1'b0;
    if (load_i) begin
      phase_d = load_val_i;
    end else if (step_i) begin
      phase_d = sum_c[PHASE_W-1:0];
      carry_c = sum_c[PHASE_W];
    end
    rel_c = REL_W'((phase_q + (inc_i >> 1)) >> (PHASE_W - REL_W));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/sl_pos_gen.sv
// Vertical scanline-phase generator: per-line relative position plus 2-cycle aligned video/sync stream.
// Optional SL_FIELD_OFFSET_EN adds field_i for a half-line phase shift on odd interlaced fields.
module sl_pos_gen
  import sl_pos_gen_pkg::*;
#(
  parameter int unsigned COLOR_W = COLOR_W_DEF,
  parameter int unsigned PHASE_W = PHASE_W_DEF
) (
  input  logic                 VCLK_i,
  input  logic                 VRST_i,
  input  logic                 HSYNC_i,
  input  logic                 VSYNC_i,
  input  logic                 DE_i,
  input  logic [3*COLOR_W-1:0] vdata_i,
  input  logic [PHASE_W-1:0]   vpos_inc_i,
  input  logic [PHASE_W-1:0]   vpos_offset_i,
`ifdef SL_FIELD_OFFSET_EN
  input  logic                 field_i,
`endif
  output logic                 HSYNC_o,
  output logic                 VSYNC_o,
  output logic                 DE_o,
  output logic [3*COLOR_W-1:0] vdata_o,
  output logic [REL_W-1:0]     sl_rel_pos_o,
  output logic                 sl_valid_o,
  output logic                 src_line_strobe_o
);

  localparam int unsigned DATA_W = 3 * COLOR_W;
  localparam int unsigned VID_W  = DATA_W + 3;
  localparam int unsigned HS_B   = VID_W - 1;
  localparam int unsigned VS_B   = VID_W - 2;
  localparam int unsigned DE_B   = VID_W - 3;

  logic [VID_W-1:0]   vid_q [PIPE_DEPTH];
  logic [VID_W-1:0]   vid_d [PIPE_DEPTH];
  logic [0:0]         state_q, state_d;
  logic [REL_W-1:0]   rel_q, rel_d;
  logic               valid_q, valid_d;
  logic               strobe_q, strobe_d;
  logic               vs_fall_c, de_fall_c, de_o_rise_c, step_c, carry_c;
  logic [PHASE_W-1:0] load_val_c;
  logic [REL_W-1:0]   rel_c;

  // First delay stage doubles as the registered copy used for edge detection.
  always_comb begin
    vs_fall_c   = (vid_q[0][VS_B] != SYNC_ACTIVE) && (VSYNC_i == SYNC_ACTIVE);
    de_fall_c   = vid_q[0][DE_B] & ~DE_i;
    de_o_rise_c = vid_q[PIPE_DEPTH-2][DE_B] & ~vid_q[PIPE_DEPTH-1][DE_B];
    vid_d[0]    = {HSYNC_i, VSYNC_i, DE_i, vdata_i};
    for (int unsigned i = 1; i < PIPE_DEPTH; i++) begin
      vid_d[i] = vid_q[i-1];
    end
  end

  always_comb begin
`ifdef SL_FIELD_OFFSET_EN
    load_val_c = vpos_offset_i + (field_i ? (vpos_inc_i >> 1) : '0);
`else
    load_val_c = vpos_offset_i;
`endif
  end

  // Next state and output register inputs.
  always_comb begin
    state_d  = state_q;
    step_c   = 1'b0;
    rel_d    = rel_q;
    if (vs_fall_c) begin
      state_d = ST_FRAME;
    end else if ((state_q == ST_FRAME) && de_fall_c) begin
      step_c = 1'b1;
    end
    strobe_d = step_c & carry_c;
    valid_d  = (state_d == ST_FRAME);
    if ((state_q == ST_FRAME) && de_o_rise_c) begin
      rel_d = rel_c;
    end
  end

  sl_phase_acc #(
    .PHASE_W(PHASE_W)
  ) u_acc (
    .clk       (VCLK_i),
    .rst       (VRST_i),
    .load_i    (vs_fall_c),
    .step_i    (step_c),
    .load_val_i(load_val_c),
    .inc_i     (vpos_inc_i),
    .carry_c   (carry_c),
    .rel_c     (rel_c)
  );

  always_ff @(posedge VCLK_i) begin
    if (VRST_i) begin
      state_q  <= ST_IDLE;
      rel_q    <= '0;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
      for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
        vid_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      rel_q    <= rel_d;
      valid_q  <= valid_d;
      strobe_q <= strobe_d;
      for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
        vid_q[i] <= vid_d[i];
      end
    end
  end

  assign HSYNC_o           = vid_q[PIPE_DEPTH-1][HS_B];
  assign VSYNC_o           = vid_q[PIPE_DEPTH-1][VS_B];
  assign DE_o              = vid_q[PIPE_DEPTH-1][DE_B];
  assign vdata_o           = vid_q[PIPE_DEPTH-1][DATA_W-1:0];
  assign sl_rel_pos_o      = rel_q;
  assign sl_valid_o        = valid_q;
  assign src_line_strobe_o = strobe_q;

endmodule

// File: tb/tb_sl_pos_gen.sv
// Scoreboard bench for sl_pos_gen: per-line expected position/strobe queued by stimulus, checked by a monitor.
module tb_sl_pos_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hs = 1'b1, vs = 1'b1, de = 1'b0;
  logic [23:0] vdat = '0;
  logic [15:0] inc = 16'h8000, off = 16'h0000;
`ifdef SL_FIELD_OFFSET_EN
  logic        field = 1'b0;
`endif

  logic        hs_o, vs_o, de_o, valid_o, strobe_o;
  logic [23:0] vdat_o;
  logic [7:0]  rel_o;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] rel_q [$];
  logic       stb_q [$];

  always #5 clk = ~clk;

  sl_pos_gen dut (
    .VCLK_i           (clk),
    .VRST_i           (rst),
    .HSYNC_i          (hs),
    .VSYNC_i          (vs),
    .DE_i             (de),
    .vdata_i          (vdat),
    .vpos_inc_i       (inc),
    .vpos_offset_i    (off),
`ifdef SL_FIELD_OFFSET_EN
    .field_i          (field),
`endif
    .HSYNC_o          (hs_o),
    .VSYNC_o          (vs_o),
    .DE_o             (de_o),
    .vdata_o          (vdat_o),
    .sl_rel_pos_o     (rel_o),
    .sl_valid_o       (valid_o),
    .src_line_strobe_o(strobe_o)
  );

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Monitor: 2-cycle video alignment every cycle, position at each DE_o rise, strobe per line at DE_o fall.
  logic [26:0] h1 = '0, h2 = '0;
  logic        prev_de = 1'b0, seen = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      h1 = '0; h2 = '0; prev_de = 1'b0; seen = 1'b0;
    end else begin
      chk("video_delay", 32'({hs_o, vs_o, de_o, vdat_o}), 32'(h2));
      h2 = h1;
      h1 = {hs, vs, de, vdat};
      if (strobe_o) seen = 1'b1;
      if (de_o && !prev_de) begin
        if (rel_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL rel_pos: got line with %0h expected no line", rel_o);
        end else chk("rel_pos", 32'(rel_o), 32'(rel_q.pop_front()));
      end
      if (!de_o && prev_de) begin
        if (stb_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL strobe: got line end expected no line");
        end else chk("strobe", 32'(seen), 32'(stb_q.pop_front()));
        seen = 1'b0;
      end
      prev_de = de_o;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    vdat = 24'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic line(input logic [7:0] rel, input logic stb);
    rel_q.push_back(rel);
    stb_q.push_back(stb);
    de = 1'b1; idle(6);
    de = 1'b0; idle(1);
    hs = 1'b0; idle(2);
    hs = 1'b1; idle(2);
  endtask

  task automatic frame_start();
    vs = 1'b0; idle(3);
    vs = 1'b1; idle(3);
  endtask

  initial begin
    idle(3);
    chk("reset_outputs", 32'({hs_o, vs_o, de_o, vdat_o}), 32'(0));
    chk("reset_valid", 32'(valid_o), 32'(0));
    chk("reset_rel", 32'(rel_o), 32'(0));
    rst = 1'b0;
    idle(2);

    // Lines before any vsync: IDLE, no position or strobe.
    line(8'h00, 1'b0);
    chk("idle_valid", 32'(valid_o), 32'(0));

    // Half-line step.
    inc = 16'h8000; off = 16'h0000;
    frame_start();
    chk("frame_valid", 32'(valid_o), 32'(1));
    line(8'h40, 1'b0); line(8'hC0, 1'b1); line(8'h40, 1'b0); line(8'hC0, 1'b1);

    // One-third step: 3*0x5555 = 0xFFFF, so the first wrap is on the 4th step.
    inc = 16'h5555; off = 16'h0000;
    frame_start();
    line(8'h2A, 1'b0); line(8'h7F, 1'b0); line(8'hD5, 1'b0); line(8'h2A, 1'b1); line(8'h7F, 1'b0);

    // Offset just below wrap: mid wraps to 0, first step carries.
    inc = 16'h0020; off = 16'hFFF0;
    frame_start();
    line(8'h00, 1'b1); line(8'h00, 1'b0);

    // Frame load and line step on the same edge: load wins, no strobe.
    inc = 16'hF000; off = 16'h1234;
    frame_start();
    off = 16'h0000;
    rel_q.push_back(8'h8A); stb_q.push_back(1'b0);
    de = 1'b1; idle(6);
    de = 1'b0; vs = 1'b0; idle(3);
    vs = 1'b1; idle(3);
    line(8'h78, 1'b0); line(8'h68, 1'b1);

    // Reset mid-line in FRAME (P=0xE000, mid 0x5800).
    rel_q.push_back(8'h58); stb_q.push_back(1'b0);
    de = 1'b1; idle(4);
    rst = 1'b1; tick();
    rst = 1'b0;
    chk("midrst_outputs", 32'({hs_o, vs_o, de_o, vdat_o}), 32'(0));
    chk("midrst_valid", 32'(valid_o), 32'(0));
    chk("midrst_rel", 32'(rel_o), 32'(0));
    chk("midrst_strobe", 32'(strobe_o), 32'(0));
    rel_q.delete(); stb_q.delete();
    rel_q.push_back(8'h00); stb_q.push_back(1'b0);
    idle(2);
    de = 1'b0; idle(5);
    line(8'h00, 1'b0);
    chk("postrst_valid", 32'(valid_o), 32'(0));

    // Zero increment: position frozen at offset, never strobes.
    inc = 16'h0000; off = 16'hAB12;
    frame_start();
    chk("postrst_frame_valid", 32'(valid_o), 32'(1));
    line(8'hAB, 1'b0); line(8'hAB, 1'b0);

`ifdef SL_FIELD_OFFSET_EN
    inc = 16'h8000; off = 16'h0000; field = 1'b1;
    frame_start();
    line(8'h80, 1'b0);
    field = 1'b0;
    frame_start();
    line(8'h40, 1'b0);
`endif

    for (int i = 0; i < 50 && (rel_q.size() != 0 || stb_q.size() != 0); i++) tick();
    if (rel_q.size() != 0 || stb_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL drain: got %0d lines pending expected 0", rel_q.size() + stb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
